// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter.
// Covers the legal aluCtr codes, the FSM state encoding and a ctr legality helper.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CTR_W  = 4;

  localparam logic [CTR_W-1:0] CTR_AND = 4'b0000;
  localparam logic [CTR_W-1:0] CTR_OR  = 4'b0001;
  localparam logic [CTR_W-1:0] CTR_ADD = 4'b0010;
  localparam logic [CTR_W-1:0] CTR_SUB = 4'b0110;
  localparam logic [CTR_W-1:0] CTR_SLT = 4'b0111;
  localparam logic [CTR_W-1:0] CTR_NOR = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  function automatic logic ctr_is_legal(input logic [CTR_W-1:0] ctr);
    logic ok;
    case (ctr)
      CTR_AND, CTR_OR, CTR_ADD, CTR_SUB, CTR_SLT, CTR_NOR: ok = 1'b1;
      default:                                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of the ALU arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [CTR_W-1:0]  req0_ctr;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [CTR_W-1:0]  req1_ctr;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_res;
  logic              rsp_zero;
  logic              rsp_err;
  logic [DATA_W-1:0] alu_input1;
  logic [DATA_W-1:0] alu_input2;
  logic [CTR_W-1:0]  alu_ctr;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req0_ctr, req0_a, req0_b,
    input  req1_valid, req1_ctr, req1_a, req1_b,
    input  alu_res, alu_zero,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_res, rsp_zero, rsp_err,
    output alu_input1, alu_input2, alu_ctr
  );

  modport master (
    output req0_valid, req0_ctr, req0_a, req0_b,
    output req1_valid, req1_ctr, req1_a, req1_b,
    output alu_res, alu_zero,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_res, rsp_zero, rsp_err,
    input  alu_input1, alu_input2, alu_ctr
  );

endinterface

// File: rtl/alu_rr_arb.sv
// Two-way round-robin grant: a lone requester wins, on a tie the one
// that did not win last time wins.
module alu_rr_arb (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  // one-hot grant from current valids and previous winner
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11: begin
        if (i_last_grant) begin
          o_grant = 2'b01;
        end else begin
          o_grant = 2'b10;
        end
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters with a
// fixed IDLE -> EXEC -> RESP sequence (accept at N, response in cycle N+2).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit CHECK_CTR = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  alu_arbiter_if.slave  io_bus
);

  state_e              r_state;
  logic                r_last_grant;
  logic [1:0]          r_gnt;
  logic                r_err;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [CTR_W-1:0]    r_alu_ctr;
  logic [1:0]          r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_res;
  logic                r_rsp_zero;
  logic                r_rsp_err;

  logic [1:0]          w_valid;
  logic [1:0]          w_grant;
  logic [CTR_W-1:0]    w_sel_ctr;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic                w_illegal;

  // the grant decision is only taken while idle; later arrivals simply wait
  always_comb begin
    w_valid = 2'b00;
    if (r_state == ST_IDLE) begin
      w_valid = {io_bus.req1_valid, io_bus.req0_valid};
    end else begin
      w_valid = 2'b00;
    end
  end

  alu_rr_arb u_rr_arb (
    .i_valid      (w_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // operand mux for the granted requester
  always_comb begin
    w_sel_ctr = io_bus.req0_ctr;
    w_sel_a   = io_bus.req0_a;
    w_sel_b   = io_bus.req0_b;
    if (w_grant[1]) begin
      w_sel_ctr = io_bus.req1_ctr;
      w_sel_a   = io_bus.req1_a;
      w_sel_b   = io_bus.req1_b;
    end else begin
      w_sel_ctr = io_bus.req0_ctr;
      w_sel_a   = io_bus.req0_a;
      w_sel_b   = io_bus.req0_b;
    end
    w_illegal = (CHECK_CTR == 1'b1) && !ctr_is_legal(w_sel_ctr);
  end

  // FSM with captured operands and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_gnt        <= 2'b00;
      r_err        <= 1'b0;
      r_alu_a      <= {DATA_W{1'b0}};
      r_alu_b      <= {DATA_W{1'b0}};
      r_alu_ctr    <= 4'b0000;
      r_rsp_valid  <= 2'b00;
      r_rsp_res    <= {DATA_W{1'b0}};
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant != 2'b00) begin
            r_gnt        <= w_grant;
            r_last_grant <= w_grant[1];
            r_err        <= w_illegal;
            r_alu_a      <= w_sel_a;
            r_alu_b      <= w_sel_b;
            r_alu_ctr    <= w_illegal ? 4'b0000 : w_sel_ctr;
            r_state      <= ST_EXEC;
          end else begin
            r_state      <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          r_rsp_valid <= r_gnt;
          r_rsp_res   <= r_err ? {DATA_W{1'b0}} : io_bus.alu_res;
          r_rsp_zero  <= r_err ? 1'b0 : io_bus.alu_zero;
          r_rsp_err   <= r_err;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          r_rsp_valid <= 2'b00;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign io_bus.req0_ready = w_grant[0];
  assign io_bus.req1_ready = w_grant[1];
  assign io_bus.rsp_valid  = r_rsp_valid;
  assign io_bus.rsp_res    = r_rsp_res;
  assign io_bus.rsp_zero   = r_rsp_zero;
  assign io_bus.rsp_err    = r_rsp_err;
  assign io_bus.alu_input1 = r_alu_a;
  assign io_bus.alu_input2 = r_alu_b;
  assign io_bus.alu_ctr    = r_alu_ctr;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus hand sequences for
// round-robin, reset during EXEC and request withdrawal, backed by a scoreboard.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if bus();

  alu_arbiter #(.CHECK_CTR(1'b1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  typedef struct {
    logic        gid;
    logic [3:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  typedef struct {
    logic [1:0]  gnt;
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          cyc;
  } sb_ent_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  sb_ent_t sb[$];
  vec_t vecs[10];

  always @(posedge clk) cyc <= cyc + 1;

  // reference ALU: {err, zero, res}
  function automatic logic [33:0] ref_alu(input logic [3:0] ctr, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    e = 1'b0;
    r = 32'd0;
    case (ctr)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      default: e = 1'b1;
    endcase
    return {e, (!e && (r == 32'd0)), r};
  endfunction

  // external ALU model
  logic [33:0] alu_w;
  assign alu_w        = ref_alu(bus.alu_ctr, bus.alu_input1, bus.alu_input2);
  assign bus.alu_res  = alu_w[31:0];
  assign bus.alu_zero = (alu_w[31:0] == 32'd0);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: push on handshake, pop on response
  sb_ent_t     m_ent;
  logic [33:0] m_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.req0_valid && bus.req0_ready) begin
        m_e = ref_alu(bus.req0_ctr, bus.req0_a, bus.req0_b);
        sb.push_back('{2'b01, m_e[31:0], m_e[32], m_e[33], cyc + 2});
      end
      if (bus.req1_valid && bus.req1_ready) begin
        m_e = ref_alu(bus.req1_ctr, bus.req1_a, bus.req1_b);
        sb.push_back('{2'b10, m_e[31:0], m_e[32], m_e[33], cyc + 2});
      end
      if (bus.rsp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_rsp", bus.rsp_valid, 2'b00);
        end else begin
          m_ent = sb.pop_front();
          check("sb_gnt", bus.rsp_valid, m_ent.gnt);
          check("sb_res", bus.rsp_res, m_ent.res);
          check("sb_zero", bus.rsp_zero, m_ent.zero);
          check("sb_err", bus.rsp_err, m_ent.err);
          check("sb_latency", cyc, m_ent.cyc);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_ctr = 4'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_ctr = 4'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 2'b00);
    check({tag, "_rsp_res"}, bus.rsp_res, 32'd0);
    check({tag, "_rsp_zero"}, bus.rsp_zero, 1'b0);
    check({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
    check({tag, "_alu_in1"}, bus.alu_input1, 32'd0);
    check({tag, "_alu_in2"}, bus.alu_input2, 32'd0);
    check({tag, "_alu_ctr"}, bus.alu_ctr, 4'b0000);
  endtask

  task automatic run_op(input vec_t v);
    logic got;
    int   t0;
    @(posedge clk); #1;
    if (v.gid) begin
      bus.req1_valid = 1'b1; bus.req1_ctr = v.ctr; bus.req1_a = v.a; bus.req1_b = v.b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_ctr = v.ctr; bus.req0_a = v.a; bus.req0_b = v.b;
    end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = v.gid ? bus.req1_ready : bus.req0_ready;
    end
    check("op_ready", got, 1'b1);
    t0 = cyc;
    @(posedge clk); #1;
    // scramble the port data after acceptance: only captured values may reach the ALU
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = $urandom; bus.req0_b = $urandom; bus.req0_ctr = 4'($urandom_range(0, 15));
    bus.req1_a = $urandom; bus.req1_b = $urandom; bus.req1_ctr = 4'($urandom_range(0, 15));
    @(negedge clk);
    check("op_alu_in1", bus.alu_input1, v.a);
    check("op_alu_in2", bus.alu_input2, v.b);
    check("op_alu_ctr", bus.alu_ctr, v.err ? 4'b0000 : v.ctr);
    check("op_exec_no_rsp", bus.rsp_valid, 2'b00);
    @(negedge clk);
    check("op_rsp_valid", bus.rsp_valid, v.gid ? 2'b10 : 2'b01);
    check("op_rsp_res", bus.rsp_res, v.res);
    check("op_rsp_zero", bus.rsp_zero, v.zero);
    check("op_rsp_err", bus.rsp_err, v.err);
    check("op_latency", cyc - t0, 2);
    @(negedge clk);
    check("op_rsp_drop", bus.rsp_valid, 2'b00);
    check("op_res_hold", bus.rsp_res, v.res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rsp_order [4];
    int         rsp_cyc [4];
    logic [1:0] exp_order [4];
    int         nrsp;
    int         nacc;
    int         bad;
    int         good;
    logic       got;

    vecs[0] = '{1'b0, 4'b0010, 32'd2,          32'd1,          32'd3,          1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'b0110, 32'd1,          32'd1,          32'd0,          1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'b0000, 32'hF0F0_00FF,  32'h0FF0_0F0F,  32'h00F0_000F,  1'b0, 1'b0};
    vecs[3] = '{1'b1, 4'b0001, 32'hF0F0_0000,  32'h0000_00FF,  32'hF0F0_00FF,  1'b0, 1'b0};
    vecs[4] = '{1'b0, 4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
    vecs[5] = '{1'b1, 4'b0111, 32'd5,          32'd3,          32'd0,          1'b1, 1'b0};
    vecs[6] = '{1'b0, 4'b1100, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[7] = '{1'b1, 4'b1111, 32'd7,          32'd8,          32'd0,          1'b0, 1'b1};
    vecs[8] = '{1'b0, 4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
    vecs[9] = '{1'b0, 4'b1111, 32'd9,          32'd9,          32'd0,          1'b0, 1'b1};
    exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};

    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    check("reset_ready0", bus.req0_ready, 1'b0);
    check("reset_ready1", bus.req1_ready, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // both requesters held valid from reset: grants alternate 0,1,0,1
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_ctr = 4'b0010; bus.req0_a = 32'd10; bus.req0_b = 32'd20;
    bus.req1_valid = 1'b1; bus.req1_ctr = 4'b0110; bus.req1_a = 32'd20; bus.req1_b = 32'd20;
    nrsp = 0;
    nacc = 0;
    for (int i = 0; i < 40 && nrsp < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) begin
        rsp_order[nrsp] = bus.rsp_valid;
        rsp_cyc[nrsp]   = cyc;
        nrsp++;
      end
      if (bus.req0_ready || bus.req1_ready) nacc++;
      if (nacc == 4 && bus.req0_valid) begin
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
    end
    check("rr_count", nrsp, 4);
    for (int k = 0; k < nrsp; k++) check("rr_order", rsp_order[k], exp_order[k]);
    for (int k = 1; k < nrsp; k++) check("rr_spacing", rsp_cyc[k] - rsp_cyc[k-1], 3);

    // reset asserted while an operation sits in EXEC
    @(posedge clk); #1;
    bus.req1_valid = 1'b1; bus.req1_ctr = 4'b0010; bus.req1_a = 32'd5; bus.req1_b = 32'd6;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.req1_ready;
    end
    check("rst_pre_ready", got, 1'b1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_exec");
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != 2'b00) bad++;
    end
    check("rst_no_rsp", bad, 0);
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_ctr = 4'b0001; bus.req0_a = 32'h0F; bus.req0_b = 32'hF0;
    bus.req1_valid = 1'b1; bus.req1_ctr = 4'b0010; bus.req1_a = 32'd1; bus.req1_b = 32'd1;
    @(negedge clk);
    check("rst_first_grant", {bus.req1_ready, bus.req0_ready}, 2'b01);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_after_rsp", bus.rsp_valid, 2'b01);
    check("rst_after_res", bus.rsp_res, 32'hFF);

    // requester 1 withdraws while requester 0 is being served
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_ctr = 4'b0010; bus.req0_a = 32'd3; bus.req0_b = 32'd4;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = bus.req0_ready;
    end
    check("wd_ready0", got, 1'b1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_ctr = 4'b0010; bus.req1_a = 32'd1; bus.req1_b = 32'd2;
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    bad = 0;
    good = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.req1_ready || bus.rsp_valid[1]) bad++;
      if (bus.rsp_valid == 2'b01) good++;
    end
    check("wd_no_req1", bad, 0);
    check("wd_req0_rsp", good, 1);
    run_op(vecs[0]);

    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CHECK_CTR, default 1, meaning 1 = reject aluCtr codes outside the legal set, 0 = pass any code to the ALU.
REQ-002 Clock, reset and ports:
- clk  in  1  rising-edge clock, single domain.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req0_valid  in  1  requester 0 (datapath) has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_ctr  in  4  requester 0 aluCtr code.
- req0_a, req0_b  in  32 each  requester 0 operands.
- req1_valid, req1_ready, req1_ctr, req1_a, req1_b  same widths, requester 1 (branch/address unit).
- rsp_valid  out  2  one-hot result strobe; bit g marks requester g.
- rsp_res  out  32  result.
- rsp_zero  out  1  ALU zero flag.
- rsp_err  out  1  illegal ctr code.
- alu_input1, alu_input2  out  32 each  to ALU input1/input2.
- alu_ctr  out  4  to ALU aluCtr.
- alu_res  in  32  from ALU aluRes.
- alu_zero  in  1  from ALU zero.

Function
REQ-003 The block SHALL share one combinational ALU between two requesters using a three-state FSM: IDLE, EXEC, RESP.
REQ-004 IDLE: with no req valid, the FSM SHALL stay in IDLE with all ready low.
REQ-005 IDLE, exactly one req valid: that requester SHALL be granted.
REQ-006 IDLE, both valid: the requester not equal to last_grant SHALL be granted (round-robin).
REQ-007 reqG_ready SHALL be high combinationally only in IDLE for the granted G; ctr/a/b SHALL be captured on that edge; the FSM SHALL move to EXEC; last_grant SHALL become G.
REQ-008 Requesters SHALL hold valid and data stable until ready; valid deasserted before ready is a legal withdrawal, and no grant SHALL be lost to it.
REQ-009 alu_input1/alu_input2/alu_ctr SHALL be driven only from the captured registers, never directly from req ports.
REQ-010 EXEC: one cycle; alu_res/alu_zero SHALL be registered at its end; the FSM SHALL then go to RESP.
REQ-011 RESP: rsp_valid[G]=1 for exactly one cycle with rsp_res/rsp_zero/rsp_err valid; the FSM SHALL return to IDLE.
REQ-012 Latency SHALL be fixed: accept at edge N, rsp_valid high in cycle N+2; throughput SHALL be one operation per 3 cycles.
REQ-013 rsp_res/rsp_zero/rsp_err SHALL hold their last value while rsp_valid=0.
REQ-014 Legal ctr set: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-015 With CHECK_CTR=1 and an illegal ctr, the response SHALL still occur at N+2 with rsp_err=1, rsp_res=0, rsp_zero=0.
REQ-016 With CHECK_CTR=1 and an illegal ctr, alu_ctr SHALL be driven 0000.
REQ-017 Requests arriving in EXEC or RESP SHALL wait; the grant decision SHALL be made only in IDLE.

Reset
REQ-018 rst_n low SHALL, from any state, force: FSM=IDLE, last_grant=1 (requester 0 wins first tie), rsp_valid=00, rsp_res=0, rsp_zero=0, rsp_err=0, alu_input1=alu_input2=0, alu_ctr=0000.
REQ-019 Reset mid-operation SHALL discard the operation; no response SHALL be issued for it after release.

Structure
REQ-020 A shared package alu_pkg SHALL hold the 4-bit ctr constants for the legal set and the FSM state encoding.
REQ-021 The round-robin grant logic SHALL be one sub-module, alu_rr_arb, with inputs valid[1:0] and last_grant, and output one-hot grant.

Verification
REQ-022 Req0: ctr 0010, a=2, b=1 -> ready at N, rsp_valid=01 at N+2, rsp_res=3, zero=0.
REQ-023 Req1: ctr 0110, a=1, b=1 -> rsp_valid=10, rsp_res=0, zero=1.
REQ-024 Both valid from reset, held for 4 operations -> grant order 0,1,0,1; rsp_valid pulses every 3 cycles.
REQ-025 Req0: ctr 1111, CHECK_CTR=1 -> alu_ctr=0000; at N+2 rsp_err=1, rsp_res=0.
REQ-026 rst_n pulsed low during EXEC -> rsp_valid stays 00 and outputs are at reset values; a following request completes normally with last_grant=1 behaviour.
REQ-027 Req1 valid withdrawn before ready while req0 is busy -> no rsp_valid[1] pulse, FSM returns to IDLE.
